fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the instruction-fetch stage and the decoder.
- Accepts one fetched instruction per cycle from IF, tagged with its pc, branch prediction and fetch-exception info.
- Presents one entry per cycle to decode in strict program order.
- Backend redirects (branch mistake, exception, ertn) flush all buffered entries in one cycle.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not to be overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  discard all entries, including any push in the same cycle
- in_valid  in  1  IF offers an entry
- in_ready  out  1  queue can accept this cycle
- in_pc  in  32  fetch pc
- in_inst  in  32  instruction word
- in_pred_taken  in  1  predictor says taken
- in_pred_target  in  32  predicted target
- in_excp  in  1  fetch-side exception (ADEF/TLB/PIF/PPI)
- in_ecode  in  6  fetch exception code
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode consumes head this cycle
- out_pc  out  32  head fields, same meaning as in_*
- out_inst  out  32
- out_pred_taken  out  1
- out_pred_target  out  32
- out_excp  out  1
- out_ecode  out  6
- count  out  PTR_W+1  current occupancy

Behaviour:
- Storage is a circular buffer with head pointer, tail pointer and an occupancy counter of PTR_W+1 bits. Pointers wrap from DEPTH-1 to 0.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- Transfer rule: a transfer happens only when valid and ready are both high on the same rising edge. in_ready must not depend combinationally on in_valid. out_valid must not depend on out_ready.
- in_ready = (count != DEPTH) | out_ready. A push into a full queue is allowed when a pop happens in the same cycle.
- out_valid = (count != 0).
- Latency: an entry pushed in cycle N appears at the output in cycle N+1 at the earliest.
- out_* are read combinationally from the head slot. When out_valid=0, out_* are don't-care, except out_excp, which is forced to 0.
- Pointer and count update, per cycle:
  - push only: tail+1, count+1.
  - pop only: head+1, count-1.
  - push and pop together: both pointers advance, count unchanged.
- On full: in_ready=0 unless out_ready=1. When in_ready=0 with in_valid=1, IF must hold its entry; the queue drops nothing.
- On empty: out_valid=0, and out_ready is ignored.
- flush:
  - Next cycle: head=tail=0, count=0, out_valid=0, in_ready=1.
  - Any push or pop presented in the flush cycle is discarded.
  - flush overrides everything except reset.
- Fetch exceptions: an entry with in_excp=1 is stored like any other. The queue never drops or reorders it. in_inst may be garbage; the decoder must not raise INE for that entry.
- Reset: when rst_n=0 at a clock edge, head=tail=0, count=0, out_valid=0, in_ready=1 after the edge. Reset mid-stream discards all entries. Storage contents are not cleared.
- No internal state machine besides the pointers and counter. All outputs derive from registered state, plus out_ready in in_ready only.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0 and in_valid=1 and !flush, in_* drive out_* combinationally and out_valid=1 in the same cycle.
  - If out_ready=1, the entry is consumed and not written; pointers and count are unchanged.
  - If out_ready=0, the entry is written normally.
  - Latency through an empty queue is 0 cycles.
- Not defined: no combinational in-to-out path; minimum latency is 1 cycle, as above.

Test Plan:
- Ordered streaming, bypass off: push pc=0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles with out_ready=1 -> each appears one cycle after its push, in order; count stays at most 1.
- Fill and backpressure: out_ready=0, push 8 entries -> count=8, in_ready=0. Hold in_valid=1 with pc=0x1c000020 -> nothing written. Raise out_ready for one cycle -> head pc=0x1c000000 popped, 0x1c000020 accepted in the same cycle, count stays 8.
- Flush with traffic: 5 entries queued; in the same cycle assert flush, in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1. A following push of pc=0x1c000100 is the first entry output.
- Wrap-around: push and pop continuously for 20 cycles -> out_pc sequence exactly matches the push order through two pointer wraps; count never exceeds DEPTH.
- Exception passthrough: push in_excp=1, in_ecode=6'h08, in_inst=32'hdeadbeef -> output shows excp=1, ecode=6'h08 in order between its neighbours. out_excp=0 whenever out_valid=0.
- Reset mid-operation: 3 entries queued, rst_n=0 for one edge -> count=0, out_valid=0, in_ready=1. With FETCH_QUEUE_BYPASS_EN, a push to the empty queue with out_ready=1 -> out_valid=1 in the same cycle, count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular buffer with single-cycle flush.
// Optional same-cycle bypass through an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_pred_taken,
  input  logic [31:0]      in_pred_target,
  input  logic             in_excp,
  input  logic [5:0]       in_ecode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_pred_taken,
  output logic [31:0]      out_pred_target,
  output logic             out_excp,
  output logic [5:0]       out_ecode,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        excp;
    logic [5:0]  ecode;
  } entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;

  entry_t in_entry;
  entry_t out_entry;
  logic   not_empty;
  logic   bypass;
  logic   push;
  logic   pop;

  always_comb begin
    in_entry = '{pc:          in_pc,
                 inst:        in_inst,
                 pred_taken:  in_pred_taken,
                 pred_target: in_pred_target,
                 excp:        in_excp,
                 ecode:       in_ecode};
    not_empty = (cnt != '0);
    in_ready  = (cnt != FULL) | out_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass    = ~not_empty & in_valid & ~flush;
`else
    bypass    = 1'b0;
`endif
    out_entry = bypass ? in_entry : mem[head];
    out_valid = not_empty | bypass;
    // A bypassed entry taken by decode in the same cycle never touches storage.
    push      = in_valid & in_ready & ~flush & ~(bypass & out_ready);
    pop       = not_empty & out_ready & ~flush;
  end

  always_comb begin
    out_pc          = out_entry.pc;
    out_inst        = out_entry.inst;
    out_pred_taken  = out_entry.pred_taken;
    out_pred_target = out_entry.pred_target;
    out_excp        = out_entry.excp & out_valid;
    out_ecode       = out_entry.ecode;
    count           = cnt;
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[tail] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        cnt <= cnt - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default DEPTH=8).
module tb_fetch_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_pred_taken;
  logic [31:0] in_pred_target;
  logic        in_excp;
  logic [5:0]  in_ecode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;
  logic        out_excp;
  logic [5:0]  out_ecode;
  logic [PTR_W:0] count;

  int errors = 0;
  int checks = 0;
  int lag;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_inst         (in_inst),
    .in_pred_taken   (in_pred_taken),
    .in_pred_target  (in_pred_target),
    .in_excp         (in_excp),
    .in_ecode        (in_ecode),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target),
    .out_excp        (out_excp),
    .out_ecode       (out_ecode),
    .count           (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Non-exception entry whose side fields are derived from pc.
  task automatic offer(input logic [31:0] pc);
    in_valid       = 1'b1;
    in_pc          = pc;
    in_inst        = pc ^ 32'h00ff00ff;
    in_pred_taken  = pc[3];
    in_pred_target = pc + 32'h40;
    in_excp        = 1'b0;
    in_ecode       = 6'h00;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    offer(32'h0); in_valid = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_excp", out_excp, 0);

`ifndef FETCH_QUEUE_BYPASS_EN
    // ordered streaming
    out_ready = 1'b1;
    offer(32'h1c000000); tick;
    check("st0_valid", out_valid, 1);
    check("st0_pc", out_pc, 32'h1c000000);
    check("st0_count", count, 1);
    offer(32'h1c000004); tick;
    check("st1_pc", out_pc, 32'h1c000004);
    check("st1_count", count, 1);
    offer(32'h1c000008); tick;
    check("st2_pc", out_pc, 32'h1c000008);
    check("st2_inst", out_inst, 32'h1cff00f7);
    check("st2_taken", out_pred_taken, 1);
    check("st2_target", out_pred_target, 32'h1c000048);
    check("st2_count", count, 1);
    in_valid = 1'b0; tick;
    check("st_end_count", count, 0);
    check("st_end_valid", out_valid, 0);
`endif

    // fill and backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      offer(32'h1c000000 + 32'(4 * i)); tick;
    end
    check("full_count", count, 8);
    check("full_in_ready", in_ready, 0);
    offer(32'h1c000020); tick;
    check("full_hold_count", count, 8);
    check("full_hold_head", out_pc, 32'h1c000000);
    out_ready = 1'b1; #1;
    check("full_in_ready_pop", in_ready, 1);
    tick;
    check("full_swap_count", count, 8);
    check("full_swap_head", out_pc, 32'h1c000004);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("drain_pc", out_pc, 32'h1c000004 + 32'(4 * i));
      tick;
    end
    check("drain_count", count, 0);

    // flush with traffic
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer(32'h1c000040 + 32'(4 * i)); tick;
    end
    check("pre_flush_count", count, 5);
    offer(32'h1c000ff0); flush = 1'b1; out_ready = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    check("flush_count", count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    offer(32'h1c000100); tick;
    check("post_flush_pc", out_pc, 32'h1c000100);
    check("post_flush_count", count, 1);
    in_valid = 1'b0; out_ready = 1'b1; tick;
    check("post_flush_drain", count, 0);

    // wrap-around: continuous push and pop
`ifdef FETCH_QUEUE_BYPASS_EN
    lag = 0;
`else
    lag = 1;
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      offer(32'h1c001000 + 32'(4 * k)); #1;
      if (k >= lag) check("wrap_pc", out_pc, 32'h1c001000 + 32'(4 * (k - lag)));
      tick;
      check("wrap_count", count, 32'(lag));
      check("wrap_bound", 32'(count <= DEPTH), 1);
    end
    in_valid = 1'b0; tick;
    check("wrap_end_count", count, 0);

    // fetch exception passthrough
    out_ready = 1'b0;
    offer(32'h1c002000); tick;
    offer(32'h1c002004); in_excp = 1'b1; in_ecode = 6'h08; in_inst = 32'hdeadbeef; tick;
    offer(32'h1c002008); tick;
    in_valid = 1'b0; out_ready = 1'b1; #1;
    check("ex_a_pc", out_pc, 32'h1c002000);
    check("ex_a_excp", out_excp, 0);
    tick;
    check("ex_b_pc", out_pc, 32'h1c002004);
    check("ex_b_excp", out_excp, 1);
    check("ex_b_ecode", out_ecode, 6'h08);
    check("ex_b_inst", out_inst, 32'hdeadbeef);
    tick;
    check("ex_c_pc", out_pc, 32'h1c002008);
    check("ex_c_excp", out_excp, 0);
    tick;
    check("ex_empty_valid", out_valid, 0);
    check("ex_empty_excp", out_excp, 0);

    // reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(32'h1c002100 + 32'(4 * i)); tick;
    end
    check("pre_rst_count", count, 3);
    in_valid = 1'b0; rst_n = 1'b0; tick;
    rst_n = 1'b1; #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    offer(32'h1c003000); out_ready = 1'b1; #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_valid", out_valid, 1);
    check("byp_pc", out_pc, 32'h1c003000);
    tick;
    check("byp_count", count, 0);
`else
    check("nobyp_valid", out_valid, 0);
    tick;
    check("nobyp_count", count, 1);
    check("nobyp_pc", out_pc, 32'h1c003000);
`endif
    in_valid = 1'b0; tick;
    check("final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
